// File: rtl/cgra_config_sequencer.sv
// Config-word sequencer feeding the CGRA configuration bus: buffers (addr, data, last)
// words from a bitstream source and issues one per clock, then raises a sticky done.
module cgra_config_sequencer #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              cfg_valid_in,
  output logic              cfg_ready_out,
  input  logic [ADDR_W-1:0] cfg_addr_in,
  input  logic [DATA_W-1:0] cfg_data_in,
  input  logic              cfg_last_in,
  input  logic              config_stall_in,
  output logic [ADDR_W-1:0] config_addr_out,
  output logic [DATA_W-1:0] config_data_out,
  output logic              config_done_out,
  output logic [15:0]       word_count_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   occ;
  logic            last_seen;
  logic [1:0]      state;
  logic [SW-1:0]   settle_cnt;
  logic            full, empty, active, push, pop;

  assign full   = (occ == CW'(DEPTH));
  assign empty  = (occ == '0);
  assign active = (state == S_IDLE) || (state == S_ISSUE);
  assign head   = mem[rd_ptr];

  assign cfg_ready_out = !full && !last_seen && active;
  assign push          = cfg_valid_in && cfg_ready_out;
  assign pop           = !empty && !config_stall_in && active;

  // Storage needs no reset; the pointers and occupancy define what is valid.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= '{last: cfg_last_in, addr: cfg_addr_in, data: cfg_data_in};
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occ             <= '0;
      last_seen       <= 1'b0;
      state           <= S_IDLE;
      settle_cnt      <= '0;
      config_addr_out <= '0;
      config_data_out <= '0;
      config_done_out <= 1'b0;
      word_count_out  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      if (push && cfg_last_in) last_seen <= 1'b1;

      // Each issued word occupies the bus for exactly one cycle; all else is a no-op.
      if (pop) begin
        config_addr_out <= head.addr;
        config_data_out <= head.data;
        if (word_count_out != 16'hFFFF) word_count_out <= word_count_out + 16'd1;
      end else begin
        config_addr_out <= '0;
        config_data_out <= '0;
      end

      case (state)
        S_IDLE, S_ISSUE: begin
          if (pop) begin
            if (head.last) begin
              state      <= S_SETTLE;
              settle_cnt <= SW'(SETTLE_CYCLES);
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - SW'(1);
          if (settle_cnt == SW'(1)) begin
            state           <= S_DONE;
            config_done_out <= 1'b1;
          end
        end
        default: state <= S_DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Directed bench for cgra_config_sequencer; second instance covers SETTLE_CYCLES = 1.
module tb_cgra_config_sequencer;
  logic        clk = 1'b0;
  logic        reset_in;
  logic        valid, last, stall;
  logic [31:0] addr, data;
  logic        ready, ready1;
  logic [31:0] caddr, cdata, caddr1, cdata1;
  logic        done, done1;
  logic [15:0] cnt, cnt1;

  int total = 0;
  int bad   = 0;
  int idx, cyc;
  logic acc, m_ready, m_pop, m_last;
  logic [31:0] ea, ed;
  logic [31:0] qa[$];
  logic [31:0] qd[$];
  logic [31:0] wa [5];
  logic [31:0] wd [5];

  always #5 clk = ~clk;

  cgra_config_sequencer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .SETTLE_CYCLES(2)) dut (
    .clk_in(clk), .reset_in(reset_in), .cfg_valid_in(valid), .cfg_ready_out(ready),
    .cfg_addr_in(addr), .cfg_data_in(data), .cfg_last_in(last), .config_stall_in(stall),
    .config_addr_out(caddr), .config_data_out(cdata), .config_done_out(done),
    .word_count_out(cnt));

  cgra_config_sequencer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .SETTLE_CYCLES(1)) dut1 (
    .clk_in(clk), .reset_in(reset_in), .cfg_valid_in(valid), .cfg_ready_out(ready1),
    .cfg_addr_in(addr), .cfg_data_in(data), .cfg_last_in(last), .config_stall_in(stall),
    .config_addr_out(caddr1), .config_data_out(cdata1), .config_done_out(done1),
    .word_count_out(cnt1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    valid = 1'b0; last = 1'b0; stall = 1'b0;
    tick();
    reset_in = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic l);
    valid = v; addr = a; data = d; last = l;
  endtask

  initial begin
    // 1: reset held with valid high accepts nothing
    reset_in = 1'b1; stall = 1'b0;
    drive(1'b1, 32'hDEAD, 32'hBEEF, 1'b0);
    repeat (3) tick();
    reset_in = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t1_addr", caddr, 0);
    chk("t1_data", cdata, 0);
    chk("t1_done", done, 0);
    chk("t1_count", cnt, 0);
    chk("t1_ready", ready, 1);
    tick();
    chk("t1_addr_idle", caddr, 0);
    chk("t1_count_idle", cnt, 0);

    // 2: three back-to-back words
    drive(1'b1, 32'h00010001, 32'h5, 1'b0); tick();
    chk("t2_addr_e1", caddr, 0);
    drive(1'b1, 32'h00020001, 32'hA, 1'b0); tick();
    chk("t2_addr_e2", caddr, 32'h00010001);
    chk("t2_data_e2", cdata, 32'h5);
    drive(1'b1, 32'h00030001, 32'hFF, 1'b1); tick();
    chk("t2_addr_e3", caddr, 32'h00020001);
    chk("t2_data_e3", cdata, 32'hA);
    chk("t2_ready_e3", ready, 0);
    drive(1'b0, 32'h0, 32'h0, 1'b0); tick();
    chk("t2_addr_e4", caddr, 32'h00030001);
    chk("t2_data_e4", cdata, 32'hFF);
    tick();
    chk("t2_addr_e5", caddr, 0);
    chk("t2_done_e5", done, 0);
    tick();
    chk("t2_addr_e6", caddr, 0);
    chk("t2_done_e6", done, 1);
    chk("t2_count", cnt, 3);
    tick();
    chk("t2_done_sticky", done, 1);

    // 3: stall fills the FIFO, release drains in order
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wa[i] = 32'h00A0_0000 + 32'(i) + 1;
      wd[i] = 32'h1111 * (32'(i) + 1);
    end
    stall = 1'b1;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, wa[idx], wd[idx], idx == 4);
      acc = valid && ready;
      tick();
      chk("t3_stall_addr", caddr, 0);
      if (acc) begin
        idx++;
        if (idx == 4) chk("t3_ready_full", ready, 0);
      end
    end
    chk("t3_accepts_stalled", idx, 4);
    stall = 1'b0;
    for (int j = 0; j < 5; j++) begin
      acc = valid && ready;
      tick();
      if (acc) begin
        idx++;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
      end
      chk("t3_drain_addr", caddr, wa[j]);
      chk("t3_drain_data", cdata, wd[j]);
    end
    chk("t3_accepts_total", idx, 5);
    tick(); tick();
    chk("t3_done", done, 1);
    chk("t3_count", cnt, 5);

    // 4: single last word, SETTLE_CYCLES = 1 instance
    do_reset();
    drive(1'b1, 32'h40, 32'h1234, 1'b1); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0); tick();
    chk("t4_addr_word", caddr1, 32'h40);
    chk("t4_data_word", cdata1, 32'h1234);
    chk("t4_done_early", done1, 0);
    tick();
    chk("t4_addr_noop", caddr1, 0);
    chk("t4_done", done1, 1);
    drive(1'b1, 32'h44, 32'h5678, 1'b0);
    chk("t4_ready_after", ready1, 0);
    tick();
    chk("t4_count", cnt1, 1);
    chk("t4_addr_after", caddr1, 0);
    drive(1'b0, 32'h0, 32'h0, 1'b0);

    // 5: reset mid-stream, then a fresh stream
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i), 32'h30 + 32'(i), 1'b0);
      tick();
    end
    reset_in = 1'b1; tick(); reset_in = 1'b0;
    stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t5_addr", caddr, 0);
    chk("t5_count", cnt, 0);
    chk("t5_done", done, 0);
    chk("t5_ready", ready, 1);
    tick();
    chk("t5_empty", caddr, 0);
    drive(1'b1, 32'h100, 32'h1, 1'b0); tick();
    drive(1'b1, 32'h200, 32'h2, 1'b1); tick();
    chk("t5_w0", caddr, 32'h100);
    drive(1'b0, 32'h0, 32'h0, 1'b0); tick();
    chk("t5_w1", caddr, 32'h200);
    chk("t5_w1_data", cdata, 32'h2);
    tick(); tick();
    chk("t5_done", done, 1);
    chk("t5_count_end", cnt, 2);

    // 6: 20 words with alternating valid/stall against a queue model
    do_reset();
    idx = 0; cyc = 0; m_last = 1'b0;
    qa.delete(); qd.delete();
    while (!(idx == 20 && qa.size() == 0) && cyc < 300) begin
      drive((idx < 20) && (cyc % 3 != 2), 32'h1000 + 32'(idx), 32'(idx) * 3 + 7, idx == 19);
      stall = (cyc % 4 == 1);
      m_ready = (qa.size() < 4) && !m_last;
      chk("t6_ready", ready, m_ready);
      m_pop = (qa.size() > 0) && !stall;
      ea = 32'h0; ed = 32'h0;
      if (m_pop) begin
        ea = qa.pop_front();
        ed = qd.pop_front();
      end
      if (valid && m_ready) begin
        qa.push_back(addr);
        qd.push_back(data);
        if (last) m_last = 1'b1;
        idx++;
      end
      tick();
      chk("t6_addr", caddr, ea);
      chk("t6_data", cdata, ed);
      cyc++;
    end
    chk("t6_all_accepted", idx, 20);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    stall = 1'b0;
    tick();
    chk("t6_done_settling", done, 0);
    tick();
    chk("t6_done", done, 1);
    chk("t6_count", cnt, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cgra_config_sequencer.md
Name: cgra_config_sequencer

Overview:
- Upstream feeder for the CGRA top's configuration bus (config_addr_in / config_data_in).
- Accepts (address, data, last) config words from a bitstream source over a valid/ready handshake and buffers them in a small FIFO.
- Issues one word per clock onto the CGRA config bus, driving address 0 (no-op) whenever it has nothing to issue.
- After the last word plus a settle interval, asserts a sticky config_done for the bench or run controller.

Parameters:
ADDR_W, 32, config address width
DATA_W, 32, config data width
DEPTH, 4, FIFO entries (power of 2, >=2)
SETTLE_CYCLES, 2, no-op cycles after last word before done (>=1)

Ports:
clk_in  input  1  clock, all logic on rising edge
reset_in  input  1  synchronous, active-high reset
cfg_valid_in  input  1  source word valid
cfg_ready_out  output  1  sequencer can accept word
cfg_addr_in  input  ADDR_W  source config address
cfg_data_in  input  DATA_W  source config data
cfg_last_in  input  1  marks final word of bitstream
config_stall_in  input  1  hold issue (CGRA not taking config this cycle)
config_addr_out  output  ADDR_W  to CGRA config_addr_in; 0 = no-op
config_data_out  output  DATA_W  to CGRA config_data_in
config_done_out  output  1  sticky, bitstream fully issued and settled
word_count_out  output  16  words issued, saturates at 0xFFFF

Behaviour:
- Interface: single clock clk_in; reset_in is synchronous and active-high.
- Reset (any cycle, including mid-stream):
  - flush FIFO, clear last_seen, state IDLE
  - config_addr_out = 0, config_data_out = 0, config_done_out = 0, word_count_out = 0
  - cfg_ready_out = 1 in the cycle after reset deasserts
- Accept: a word is accepted on an edge where cfg_valid_in && cfg_ready_out.
  - cfg_ready_out = !full && !last_seen && state in {IDLE, ISSUE}; combinational from registered state.
  - No push when full, even if a pop occurs on the same edge.
  - Accepting a word with cfg_last_in = 1 sets last_seen; cfg_ready_out = 0 from then until reset.
- Issue: on each edge with FIFO non-empty, config_stall_in = 0 and state in {IDLE, ISSUE}:
  - pop the head word
  - register config_addr_out / config_data_out <= head addr / data
  - word_count_out += 1 (saturating)
- No-op: otherwise config_addr_out <= 0 and config_data_out <= 0. Every issued word is visible for exactly one cycle.
- Latency: a word accepted at edge k into an empty FIFO appears on the outputs after edge k+1. Back-to-back accepts with no stall issue on consecutive cycles.
- Simultaneous push and pop on a non-full FIFO: occupancy unchanged, ordering preserved. Pop reads the old head, never the word being pushed.
- Stall: config_stall_in = 1 blocks the pop and forces a no-op. FIFO fills and cfg_ready_out drops at DEPTH entries.
- FSM:
  - IDLE -> ISSUE on first pop
  - ISSUE -> SETTLE on the edge that pops a word tagged last; settle counter loads SETTLE_CYCLES
  - SETTLE: outputs no-op regardless of stall; counter decrements each edge; on the edge where it reaches 0, -> DONE and config_done_out <= 1
  - DONE: outputs held 0, cfg_ready_out = 0, config_done_out held 1 until reset
- Timing of done: config_done_out rises SETTLE_CYCLES cycles after the last word appears on the outputs.
- Address-0 words from the source are issued verbatim; they are indistinguishable from no-ops at the CGRA and are counted in word_count_out.
- Widths: FIFO entry is ADDR_W + DATA_W + 1 bits; occupancy counter is clog2(DEPTH)+1 bits.

Test Plan:
1. Reset -> after reset_in drops: addr/data = 0, done = 0, count = 0, ready = 1; holding reset_in = 1 for 3 cycles with valid = 1 accepts nothing.
2. Back-to-back words (00010001, 00000005), (00020001, 0000000A), (00030001, 000000FF, last) accepted at edges 1,2,3 -> outputs show them after edges 2,3,4; addr = 0 after edges 5,6; done = 1 after edge 6; count = 3; ready = 0 after edge 3.
3. Stall high for 6 cycles while source pushes 5 words -> ready drops after the 4th accept; outputs stay 0. Release stall -> the 4 words issue in order on consecutive cycles, then the 5th is accepted and issued; no loss or duplication.
4. Single word with last, SETTLE_CYCLES = 1 -> word visible one cycle, one no-op cycle, then done = 1; a later cfg_valid_in sees ready = 0 and count stays 1.
5. Reset asserted mid-stream with 3 words buffered -> next cycle outputs = 0, FIFO empty, count = 0, done = 0. A fresh 2-word stream then completes normally.
6. Alternating valid/stall pattern over 20 words, checked against a reference model -> issued sequence equals accepted sequence, one cycle minimum latency, and count = 20 at done.
